// File: rtl/ads886x_capture.sv
// Capture controller for ADS886x SAR ADCs in 3-wire CS mode: conversion timing, serial readout on a
// divided SCLK, single-shot/continuous triggering and power-of-two averaging, all in the clk domain.
module ads886x_capture #(
  parameter int DATA_W       = 16,
  parameter int CLK_DIV      = 1,
  parameter int CONV_CYCLES  = 61,
  parameter int QUIET_CYCLES = 6,
  parameter int PERIOD       = 100,
  parameter int AVG_LOG2     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] raw_data,
  output logic              raw_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  output logic              ADC_DIN,
  output logic              ADC_SCLK,
  input  logic              ADC_DOUT,
  output logic              ADC_CONV,
  output logic [2:0]        dbg_state
);

  localparam int TCNT_W = $clog2(PERIOD + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TCNT_W-1:0] CONV_LAST   = TCNT_W'(CONV_CYCLES - 1);
  localparam logic [TCNT_W-1:0] QUIET_LAST  = TCNT_W'(CONV_CYCLES + QUIET_CYCLES - 1);
  localparam logic [TCNT_W-1:0] PERIOD_LAST = TCNT_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  FCNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_QUIET = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                sclk_q, sclk_d;
  logic                conv_q, conv_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   raw_q, raw_d;
  logic                raw_valid_q, raw_valid_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [ACC_W-1:0]    sum_w;

  always_comb begin
    sum_w = ACC_W'(shift_q) + acc_q;
  end

  // tcnt_q is the cycle index within the frame: 0 at T0, the first cycle with ADC_CONV high.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q + TCNT_W'(1);
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    shift_d     = shift_q;
    raw_d       = raw_q;
    raw_valid_d = 1'b0;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    acc_d       = acc_q;
    fcnt_d      = fcnt_q;

    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        sclk_d = 1'b0;
        if (en || start) begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (tcnt_q == CONV_LAST) begin
          state_d = S_QUIET;
        end
      end
      S_QUIET: begin
        if (tcnt_q == QUIET_LAST) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[DATA_W-2:0], ADC_DOUT};
            bit_d   = bit_q + BIT_W'(1);
          end else if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        raw_d       = shift_q;
        raw_valid_d = 1'b1;
        if (fcnt_q == FCNT_LAST) begin
          avg_d       = DATA_W'(sum_w >> AVG_LOG2);
          avg_valid_d = 1'b1;
          acc_d       = '0;
          fcnt_d      = '0;
        end else begin
          acc_d  = sum_w;
          fcnt_d = fcnt_q + CNT_W'(1);
        end
        // When PERIOD equals the frame length there is no padding, so the next frame starts directly.
        if (en) begin
          if (tcnt_q == PERIOD_LAST) begin
            state_d = S_CONV;
            tcnt_d  = '0;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tcnt_q == PERIOD_LAST) begin
          state_d = en ? S_CONV : S_IDLE;
          tcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
        sclk_d  = 1'b0;
      end
    endcase

    conv_d = (state_d == S_CONV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      conv_q      <= 1'b0;
      shift_q     <= '0;
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      acc_q       <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      conv_q      <= conv_d;
      shift_q     <= shift_d;
      raw_q       <= raw_d;
      raw_valid_q <= raw_valid_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      acc_q       <= acc_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign raw_data  = raw_q;
  assign raw_valid = raw_valid_q;
  assign avg_data  = avg_q;
  assign avg_valid = avg_valid_q;
  assign ADC_DIN   = 1'b1;
  assign ADC_SCLK  = sclk_q;
  assign ADC_CONV  = conv_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ads886x_capture.sv
// Bench for ads886x_capture: three configurations (defaults, 4-frame averaging, 18-bit with CLK_DIV=2)
// driven by an ADC serial model, with a queue scoreboard checking words and pin timing.
module tb_ads886x_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en_v, start_v, dout_v;
  wire  [2:0]  busy_v, rv_v, av_v, din_v, sclk_v, conv_v;
  wire  [15:0] raw0, avg0, raw1, avg1;
  wire  [17:0] raw2, avg2;
  wire  [2:0]  st0, st1, st2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ads886x_capture u_dut0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .raw_data(raw0), .raw_valid(rv_v[0]), .avg_data(avg0), .avg_valid(av_v[0]),
    .ADC_DIN(din_v[0]), .ADC_SCLK(sclk_v[0]), .ADC_DOUT(dout_v[0]), .ADC_CONV(conv_v[0]),
    .dbg_state(st0)
  );

  ads886x_capture #(.AVG_LOG2(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .raw_data(raw1), .raw_valid(rv_v[1]), .avg_data(avg1), .avg_valid(av_v[1]),
    .ADC_DIN(din_v[1]), .ADC_SCLK(sclk_v[1]), .ADC_DOUT(dout_v[1]), .ADC_CONV(conv_v[1]),
    .dbg_state(st1)
  );

  ads886x_capture #(.DATA_W(18), .CLK_DIV(2), .PERIOD(140)) u_dut2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .start(start_v[2]), .busy(busy_v[2]),
    .raw_data(raw2), .raw_valid(rv_v[2]), .avg_data(avg2), .avg_valid(av_v[2]),
    .ADC_DIN(din_v[2]), .ADC_SCLK(sclk_v[2]), .ADC_DOUT(dout_v[2]), .ADC_CONV(conv_v[2]),
    .dbg_state(st2)
  );

  function automatic int wdt(int i);   return (i == 2) ? 18 : 16; endfunction
  function automatic int cdiv(int i);  return (i == 2) ? 2 : 1;   endfunction
  function automatic int flen(int i);  return (i == 2) ? 140 : 100; endfunction
  function automatic int per(int i);   return (i == 2) ? 140 : 100; endfunction

  function automatic logic [17:0] rawd(int i);
    case (i)
      0:       return {2'b00, raw0};
      1:       return {2'b00, raw1};
      default: return raw2;
    endcase
  endfunction

  function automatic logic [17:0] avgd(int i);
    case (i)
      0:       return {2'b00, avg0};
      1:       return {2'b00, avg1};
      default: return avg2;
    endcase
  endfunction

  // Expected-response queues (0..2 raw, 3..5 avg) and ADC model word queues (6..8).
  logic [17:0] exp_raw0[$], exp_raw1[$], exp_raw2[$];
  logic [17:0] exp_avg0[$], exp_avg1[$], exp_avg2[$];
  logic [17:0] mq0[$], mq1[$], mq2[$];

  task automatic push_q(input int sel, input logic [17:0] v);
    case (sel)
      0: exp_raw0.push_back(v);
      1: exp_raw1.push_back(v);
      2: exp_raw2.push_back(v);
      3: exp_avg0.push_back(v);
      4: exp_avg1.push_back(v);
      5: exp_avg2.push_back(v);
      6: mq0.push_back(v);
      7: mq1.push_back(v);
      default: mq2.push_back(v);
    endcase
  endtask

  function automatic logic [17:0] pop_q(input int sel, output bit ok);
    logic [17:0] v;
    v  = '0;
    ok = 1'b0;
    case (sel)
      0: if (exp_raw0.size() > 0) begin v = exp_raw0.pop_front(); ok = 1'b1; end
      1: if (exp_raw1.size() > 0) begin v = exp_raw1.pop_front(); ok = 1'b1; end
      2: if (exp_raw2.size() > 0) begin v = exp_raw2.pop_front(); ok = 1'b1; end
      3: if (exp_avg0.size() > 0) begin v = exp_avg0.pop_front(); ok = 1'b1; end
      4: if (exp_avg1.size() > 0) begin v = exp_avg1.pop_front(); ok = 1'b1; end
      5: if (exp_avg2.size() > 0) begin v = exp_avg2.pop_front(); ok = 1'b1; end
      6: if (mq0.size() > 0) begin v = mq0.pop_front(); ok = 1'b1; end
      7: if (mq1.size() > 0) begin v = mq1.pop_front(); ok = 1'b1; end
      default: if (mq2.size() > 0) begin v = mq2.pop_front(); ok = 1'b1; end
    endcase
    return v;
  endfunction

  task automatic check(input string name, input int i, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, i, act, req, cyc);
    end
  endtask

  // ADC model: the next bit appears on DOUT after each SCLK rise; a CONV rise loads the next word.
  logic [17:0] cw[3];
  int          idx[3];
  logic [2:0]  m_conv_p, m_sclk_p;
  initial begin
    bit ok;
    dout_v   = '0;
    m_conv_p = '0;
    m_sclk_p = '0;
    for (int i = 0; i < 3; i++) begin cw[i] = '0; idx[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (conv_v[i] && !m_conv_p[i]) begin
          cw[i]  = pop_q(6 + i, ok);
          idx[i] = 0;
        end
        if (sclk_v[i] && !m_sclk_p[i]) begin
          if (idx[i] < wdt(i)) dout_v[i] = cw[i][wdt(i) - 1 - idx[i]];
          idx[i]++;
        end
        m_conv_p[i] = conv_v[i];
        m_sclk_p[i] = sclk_v[i];
      end
    end
  end

  // Monitor: pin timing per frame plus scoreboard pops on every valid strobe.
  int         t0[3]         = '{0, 0, 0};
  int         conv_len[3]   = '{0, 0, 0};
  int         hi_len[3]     = '{0, 0, 0};
  int         lo_len[3]     = '{0, 0, 0};
  int         pulses[3]     = '{0, 0, 0};
  int         conv_rises[3] = '{0, 0, 0};
  int         rv_cnt[3]     = '{0, 0, 0};
  int         av_cnt[3]     = '{0, 0, 0};
  bit         t0_valid[3]   = '{0, 0, 0};
  bit         spc_chk[3]    = '{0, 0, 0};
  logic [2:0] conv_p = '0, sclk_p = '0;
  initial begin
    bit          ok;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rv_v[i]) begin
          rv_cnt[i]++;
          check("raw_latency", i, cyc - t0[i], flen(i));
          check("sclk_pulses", i, pulses[i], wdt(i));
          e = pop_q(i, ok);
          if (!ok) begin
            checks++; errors++;
            $display("FAIL unexpected_raw dut%0d: got 0x%0h, expected no strobe", i, rawd(i));
          end else check("raw_data", i, rawd(i), e);
        end
        if (av_v[i]) begin
          av_cnt[i]++;
          e = pop_q(3 + i, ok);
          if (!ok) begin
            checks++; errors++;
            $display("FAIL unexpected_avg dut%0d: got 0x%0h, expected no strobe", i, avgd(i));
          end else check("avg_data", i, avgd(i), e);
        end
        if (conv_v[i] && !conv_p[i]) begin
          conv_rises[i]++;
          if (spc_chk[i] && t0_valid[i]) check("frame_spacing", i, cyc - t0[i], per(i));
          t0[i] = cyc; t0_valid[i] = 1'b1; conv_len[i] = 0; pulses[i] = 0;
        end
        if (!conv_v[i] && conv_p[i]) check("conv_len", i, conv_len[i], 61);
        if (conv_v[i]) conv_len[i]++;
        if (sclk_v[i] && !sclk_p[i]) begin
          if (pulses[i] > 0) check("sclk_low", i, lo_len[i], cdiv(i));
          pulses[i]++;
          hi_len[i] = 0;
        end
        if (!sclk_v[i] && sclk_p[i]) begin
          check("sclk_high", i, hi_len[i], cdiv(i));
          lo_len[i] = 0;
        end
        if (sclk_v[i]) hi_len[i]++; else lo_len[i]++;
      end
      conv_p = conv_v;
      sclk_p = sclk_v;
    end
  end

  task automatic pulse_start(input logic [2:0] m);
    @(posedge clk); #1 start_v = start_v | m;
    @(posedge clk); #1 start_v = start_v & ~m;
  endtask

  task automatic wait_idle(input int i, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (!busy_v[i]) done = 1'b1;
    end
    check("idle_reached", i, done, 1);
  endtask

  task automatic wait_rises(input int i, input int target, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (conv_rises[i] >= target) done = 1'b1;
    end
    check("frame_started", i, done, 1);
  endtask

  task automatic wait_cycle(input int target, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      if (cyc == target) done = 1'b1;
    end
    check("cycle_reached", 0, done, 1);
  endtask

  task automatic dut0_word(input logic [15:0] w);
    push_q(6, {2'b00, w}); push_q(0, {2'b00, w}); push_q(3, {2'b00, w});
  endtask

  task automatic run_1357();
    logic [15:0] wl[4];
    int base;
    wl = '{16'h0001, 16'h0003, 16'h0005, 16'h0007};
    base = av_cnt[1];
    for (int k = 0; k < 4; k++) begin
      push_q(7, {2'b00, wl[k]}); push_q(1, {2'b00, wl[k]});
      if (k == 3) push_q(4, 18'h00004);
      pulse_start(3'b010);
      wait_idle(1, 300);
      check("avg_strobes", 1, av_cnt[1] - base, (k == 3) ? 1 : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_rv;
    rst = 1'b1; en_v = '0; start_v = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", i, busy_v[i], 0);
      check("rst_raw", i, rawd(i), 0);
      check("rst_avg", i, avgd(i), 0);
      check("rst_valid", i, {rv_v[i], av_v[i]}, 0);
      check("rst_pins", i, {sclk_v[i], conv_v[i], din_v[i]}, 3'b001);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Single shot, defaults, 0xA5C3
    dut0_word(16'hA5C3);
    pulse_start(3'b001);
    wait_idle(0, 300);
    check("raw_hold", 0, raw0, 16'hA5C3);
    check("idle_state", 0, st0, 0);

    // 18-bit word with CLK_DIV=2
    push_q(8, 18'h2AAAA); push_q(2, 18'h2AAAA); push_q(5, 18'h2AAAA);
    pulse_start(3'b100);
    wait_idle(2, 400);

    // Continuous, five random words
    for (int k = 0; k < 5; k++) dut0_word(16'($urandom_range(0, 65535)));
    base_rv = rv_cnt[0]; base = conv_rises[0];
    t0_valid[0] = 1'b0; spc_chk[0] = 1'b1;
    en_v[0] = 1'b1;
    wait_rises(0, base + 5, 700);
    en_v[0] = 1'b0;
    wait_idle(0, 300);
    spc_chk[0] = 1'b0;
    check("cont_strobes", 0, rv_cnt[0] - base_rv, 5);

    // Averaging: 1,3,5,7 then 0xFFFF x4 in continuous mode
    run_1357();
    for (int k = 0; k < 4; k++) begin push_q(7, 18'h0FFFF); push_q(1, 18'h0FFFF); end
    push_q(4, 18'h0FFFF);
    base = conv_rises[1];
    t0_valid[1] = 1'b0; spc_chk[1] = 1'b1;
    en_v[1] = 1'b1;
    wait_rises(1, base + 4, 500);
    en_v[1] = 1'b0;
    wait_idle(1, 300);
    spc_chk[1] = 1'b0;

    // Reset mid-frame; dut1 carries one accumulated frame into the reset
    push_q(7, 18'h00100); push_q(1, 18'h00100);
    pulse_start(3'b010);
    wait_idle(1, 300);
    push_q(6, 18'h01234); push_q(7, 18'h00200);
    base = conv_rises[0];
    pulse_start(3'b011);
    wait_rises(0, base + 1, 10);
    wait_cycle(t0[0] + 80, 200);
    rst = 1'b1;
    #1;
    check("rst_mid_conv", 0, conv_v[0], 0);
    check("rst_mid_sclk", 0, sclk_v[0], 0);
    check("rst_mid_busy", 0, busy_v[0], 0);
    check("rst_mid_pins", 1, {conv_v[1], sclk_v[1], busy_v[1]}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    base_rv = rv_cnt[0] + rv_cnt[1];
    repeat (150) @(negedge clk);
    check("no_partial_word", 0, rv_cnt[0] + rv_cnt[1], base_rv);
    dut0_word(16'h5A5A);
    pulse_start(3'b001);
    wait_idle(0, 300);
    run_1357();

    // en dropped mid-frame with an ignored start while busy
    dut0_word(16'h0F0F);
    base_rv = rv_cnt[0]; base = conv_rises[0];
    en_v[0] = 1'b1;
    wait_rises(0, base + 1, 10);
    wait_cycle(t0[0] + 30, 100);
    en_v[0] = 1'b0;
    wait_cycle(t0[0] + 50, 100);
    start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    wait_idle(0, 200);
    base = conv_rises[0];
    repeat (200) @(negedge clk);
    check("no_second_frame", 0, conv_rises[0], base);
    check("one_strobe", 0, rv_cnt[0] - base_rv, 1);
    check("idle_after", 0, busy_v[0], 0);

    check("raw_q_left", 0, exp_raw0.size(), 0);
    check("raw_q_left", 1, exp_raw1.size(), 0);
    check("raw_q_left", 2, exp_raw2.size(), 0);
    check("avg_q_left", 0, exp_avg0.size(), 0);
    check("avg_q_left", 1, exp_avg1.size(), 0);
    check("avg_q_left", 2, exp_avg2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
